cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
//  Shares the single physical-memory cacheline port between icache and dcache.
//  Sits between the two caches and main memory (cacheline adaptor).
//  Grants one requester at a time, latches its address/data, runs one
//  read or writeback transaction, then routes the response back to that cache.
// PARAMETERS
//  ADDR_WIDTH  32   byte address width; line-aligned addresses are passed through unchanged
//  LINE_WIDTH  256  cacheline width in bits
// PORTS
//  clk           in   1           system clock, rising edge
//  rst           in   1           asynchronous, active-high reset
//  i_read        in   1           icache line-fill request
//  i_addr        in   ADDR_WIDTH  icache line address
//  i_rdata       out  LINE_WIDTH  line to icache
//  i_resp        out  1           icache transaction done (1-cycle pulse)
//  d_read        in   1           dcache line-fill request
//  d_write       in   1           dcache writeback request
//  d_addr        in   ADDR_WIDTH  dcache line address
//  d_wdata       in   LINE_WIDTH  dcache writeback line
//  d_rdata       out  LINE_WIDTH  line to dcache
//  d_resp        out  1           dcache transaction done (1-cycle pulse)
//  pmem_read     out  1           memory read request
//  pmem_write    out  1           memory write request
//  pmem_address  out  ADDR_WIDTH  memory line address
//  pmem_wdata    out  LINE_WIDTH  memory write line
//  pmem_rdata    in   LINE_WIDTH  memory read line
//  pmem_resp     in   1           memory transaction done
// BEHAVIOUR
//  - FSM states: IDLE, SERVE_I, SERVE_D, DONE. Reset value: IDLE.
//  - Reset values: addr/wdata latches = 0, pmem_read/pmem_write = 0, i_resp/d_resp = 0.
//  - IDLE: grant on the same edge the request is sampled.
//    - If d_read|d_write: latch d_addr, d_wdata and op. Go to SERVE_D.
//    - Otherwise, if i_read: latch i_addr, op = read. Go to SERVE_I.
//    - Otherwise stay in IDLE.
//  - SERVE_x: pmem_read/pmem_write come from the latched op, registered state only.
//    - pmem_address/pmem_wdata are driven from the latches.
//    - Stay in SERVE_x until pmem_resp.
//  - On pmem_resp in SERVE_x:
//    - Assert x_resp combinationally in that same cycle.
//    - x_rdata = pmem_rdata, valid only while x_resp is high.
//    - Next state DONE.
//  - DONE: one dead cycle, no grant. This lets the served cache drop its request
//    and prevents a stale re-grant. Then go to IDLE.
//  - Latency:
//    - Request at cycle N gives pmem_read/pmem_write high at N+1.
//    - x_resp occurs in the same cycle as pmem_resp.
//    - Next grant no earlier than pmem_resp cycle + 2.
//  - pmem outputs are 0 in IDLE and DONE; pmem_address/pmem_wdata hold their last latch.
//  - Requesters hold their request until resp.
//    - If a request is withdrawn mid-service, the arbiter still completes the latched
//      transaction. The resp pulse is still issued.
//  - d_read & d_write both high is illegal. Write wins; a simulation-only assertion fires.
//  - pmem_resp in IDLE or DONE is ignored: no resp, no state change.
//  - i_resp and d_resp are never high in the same cycle.
//  - Only the granted cache sees a resp; i_rdata/d_rdata mirror pmem_rdata but are
//    qualified by resp.
//  - Async rst mid-transaction:
//    - FSM goes to IDLE and pmem_read/pmem_write drop immediately.
//    - A late pmem_resp is ignored.
//    - No resp is issued for the aborted transaction.
// CONFIGURATION
//  - ARB_ROUND_ROBIN_EN defined:
//    - A 1-bit last_served register is kept (reset value = icache).
//    - When both caches request in IDLE, grant goes to the one not last served.
//    - A single requester is always granted.
//  - ARB_ROUND_ROBIN_EN undefined: fixed dcache priority; no last_served register.
// TESTING
//  1. Reset then idle.
//     - rst pulse mid-cycle -> all outputs 0 asynchronously.
//     - pmem_resp=1 while idle -> i_resp=d_resp=0.
//  2. icache read.
//     - i_read=1, i_addr=0x0000_0060 -> next cycle pmem_read=1, pmem_address=0x60.
//     - Memory gives pmem_resp after 5 cycles with rdata=0xAB..AB -> i_resp=1 that
//       cycle, i_rdata=0xAB..AB.
//  3. dcache writeback.
//     - d_write=1, d_addr=0x8000_0020, d_wdata=0x1234.. -> pmem_write=1 with matching
//       address/wdata.
//     - pmem_resp -> one d_resp pulse; pmem_write=0 next cycle.
//  4. Contention.
//     - i_read and d_read both asserted from idle -> dcache served first; icache
//       served after DONE.
//     - With ARB_ROUND_ROBIN_EN and last_served=dcache: icache served first.
//  5. Back-to-back dcache.
//     - Writeback then immediate read of the same line -> two separate transactions,
//       exactly one DONE cycle between them, no duplicate grant.
//  6. Abort.
//     - rst asserted while SERVE_D waits on memory -> pmem_write drops immediately.
//     - Later pmem_resp -> no d_resp; next i_read is served normally.

Source files
------------

// File: rtl/cache_arbiter.sv
`timescale 1ns/1ps
// cache_arbiter
//   Shares the single physical-memory cacheline port between the icache and
//   the dcache. One requester is granted at a time; its address, writeback
//   data and operation are latched, one memory read or write is run, and the
//   memory response is routed back to the granted cache only. A dead DONE
//   cycle after every transaction lets the served cache drop its request so
//   it is not granted a second time.
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   : when both caches request together, the one not served last
//                 wins (last_served resets to icache).
//     undefined : fixed dcache priority.
//
//   Ports
//     clk, rst                  clock (rising edge), async active-high reset
//     i_read, i_addr            icache line-fill request and line address
//     i_rdata, i_resp           line to icache, 1-cycle done pulse
//     d_read, d_write, d_addr   dcache fill / writeback request and address
//     d_wdata                   dcache writeback line
//     d_rdata, d_resp           line to dcache, 1-cycle done pulse
//     pmem_read, pmem_write     memory request (registered)
//     pmem_address, pmem_wdata  memory line address / write line (latched)
//     pmem_rdata, pmem_resp     memory read line / transaction done
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  pmem_read_q;
  logic                  pmem_write_q;
  logic                  d_req;
  logic                  grant_d;

  assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = icache served last, 1 = dcache served last
  logic last_served_q;

  // dcache wins unless icache is also asking and dcache was served last
  assign grant_d = d_req & (~i_read | ~last_served_q);
`else
  assign grant_d = d_req;
`endif

  // Arbitration FSM with registered memory request and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_served_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            addr_q       <= d_addr;
            wdata_q      <= d_wdata;
            // write wins if both are (illegally) asserted
            pmem_write_q <= d_write;
            pmem_read_q  <= ~d_write;
            state_q      <= SERVE_D;
`ifdef ARB_ROUND_ROBIN_EN
            last_served_q <= 1'b1;
`endif
          end else if (i_read) begin
            addr_q       <= i_addr;
            pmem_read_q  <= 1'b1;
            pmem_write_q <= 1'b0;
            state_q      <= SERVE_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_served_q <= 1'b0;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          // requests are not re-examined here: a withdrawn request still completes
          if (pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            state_q      <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Response routed only to the granted cache, in the memory response cycle
  assign i_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : {LINE_WIDTH{1'b0}};
  assign d_rdata = d_resp ? pmem_rdata : {LINE_WIDTH{1'b0}};

`ifndef SYNTHESIS
  // dcache must never request a fill and a writeback together
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(d_read && d_write))
        else $error("cache_arbiter: d_read and d_write asserted together");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
`timescale 1ns/1ps
// tb_cache_arbiter
//   Directed, table-driven bench for cache_arbiter. Each table row is one
//   clock cycle: inputs driven after the falling edge, outputs compared 1 ns
//   later. Hand-written sequences cover async reset and mid-transaction abort.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [LW-1:0] AB  = {32{8'hAB}};
  localparam logic [LW-1:0] CD  = {32{8'hCD}};
  localparam logic [LW-1:0] WD  = {8{32'h1234_5678}};
  localparam logic [LW-1:0] Z   = '0;
  localparam logic [AW-1:0] A60 = 32'h0000_0060;
  localparam logic [AW-1:0] AD  = 32'h8000_0020;
  localparam logic [AW-1:0] A100 = 32'h0000_0100;
  localparam logic [AW-1:0] A40 = 32'h0000_0040;
  localparam logic [AW-1:0] A0  = 32'h0000_0000;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ir;
    logic [AW-1:0] ia;
    logic          dr;
    logic          dw;
    logic [AW-1:0] da;
    logic          pr;
    logic [LW-1:0] prd;
    logic          epr;
    logic          epw;
    logic [AW-1:0] ea;
    logic [LW-1:0] ew;
    logic          eir;
    logic          edr;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  function automatic vec_t v(input logic ir, input logic [AW-1:0] ia,
                             input logic dr, input logic dw, input logic [AW-1:0] da,
                             input logic pr, input logic [LW-1:0] prd,
                             input logic epr, input logic epw, input logic [AW-1:0] ea,
                             input logic [LW-1:0] ew, input logic eir, input logic edr);
    vec_t r;
    r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da;
    r.pr = pr; r.prd = prd;
    r.epr = epr; r.epw = epw; r.ea = ea; r.ew = ew; r.eir = eir; r.edr = edr;
    return r;
  endfunction

  task automatic chk(input string name, input int row,
                     input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic dw, input logic [AW-1:0] da,
                       input logic pr, input logic [LW-1:0] prd);
    i_read = ir; i_addr = ia; d_read = dr; d_write = dw; d_addr = da;
    d_wdata = WD; pmem_resp = pr; pmem_rdata = prd;
  endtask

  task automatic chk_all(input int row, input logic epr, input logic epw,
                         input logic [AW-1:0] ea, input logic [LW-1:0] ew,
                         input logic eir, input logic edr, input logic [LW-1:0] prd);
    chk("pmem_read",    row, LW'(pmem_read),    LW'(epr));
    chk("pmem_write",   row, LW'(pmem_write),   LW'(epw));
    chk("pmem_address", row, LW'(pmem_address), LW'(ea));
    chk("pmem_wdata",   row, pmem_wdata,        ew);
    chk("i_resp",       row, LW'(i_resp),       LW'(eir));
    chk("d_resp",       row, LW'(d_resp),       LW'(edr));
    chk("i_rdata",      row, i_rdata,           eir ? prd : Z);
    chk("d_rdata",      row, d_rdata,           edr ? prd : Z);
  endtask

  initial begin
    // idle with stray pmem_resp, then contention (dcache first)
    tbl[0]  = v(0, A0,  0, 0, A0, 1, AB, 0, 0, A0, Z,  0, 0);
    tbl[1]  = v(0, A0,  0, 0, A0, 0, Z,  0, 0, A0, Z,  0, 0);
    tbl[2]  = v(1, A60, 1, 0, AD, 0, Z,  0, 0, A0, Z,  0, 0);
    tbl[3]  = v(1, A60, 1, 0, AD, 0, Z,  1, 0, AD, WD, 0, 0);
    tbl[4]  = v(1, A60, 1, 0, AD, 1, CD, 1, 0, AD, WD, 0, 1);
    tbl[5]  = v(1, A60, 0, 0, AD, 0, Z,  0, 0, AD, WD, 0, 0);
    tbl[6]  = v(1, A60, 0, 0, A0, 0, Z,  0, 0, AD, WD, 0, 0);
    // icache fill, memory answers after 5 cycles
    for (int i = 7; i <= 11; i++)
      tbl[i] = v(1, A60, 0, 0, A0, 0, Z, 1, 0, A60, WD, 0, 0);
    tbl[12] = v(1, A60, 0, 0, A0, 1, AB, 1, 0, A60, WD, 1, 0);
    tbl[13] = v(0, A0,  0, 0, A0, 0, Z,  0, 0, A60, WD, 0, 0);
    // dcache writeback, then read of the same line; resp in DONE ignored
    tbl[14] = v(0, A0,  0, 1, AD, 0, Z,  0, 0, A60, WD, 0, 0);
    tbl[15] = v(0, A0,  0, 1, AD, 0, Z,  0, 1, AD, WD, 0, 0);
    tbl[16] = v(0, A0,  0, 1, AD, 1, AB, 0, 1, AD, WD, 0, 1);
    tbl[17] = v(0, A0,  1, 0, AD, 1, AB, 0, 0, AD, WD, 0, 0);
    tbl[18] = v(0, A0,  1, 0, AD, 0, Z,  0, 0, AD, WD, 0, 0);
    tbl[19] = v(0, A0,  1, 0, AD, 1, CD, 1, 0, AD, WD, 0, 1);
    tbl[20] = v(0, A0,  0, 0, A0, 0, Z,  0, 0, AD, WD, 0, 0);
    // icache request withdrawn mid-service still completes
    tbl[21] = v(1, A100, 0, 0, A0, 0, Z,  0, 0, AD,   WD, 0, 0);
    tbl[22] = v(0, A0,   0, 0, A0, 0, Z,  1, 0, A100, WD, 0, 0);
    tbl[23] = v(0, A0,   0, 0, A0, 1, AB, 1, 0, A100, WD, 1, 0);
    tbl[24] = v(0, A0,   0, 0, A0, 0, Z,  0, 0, A100, WD, 0, 0);
    // dcache served, then contention: round robin picks icache
    tbl[25] = v(0, A0,  1, 0, A40, 0, Z,  0, 0, A100, WD, 0, 0);
    tbl[26] = v(0, A0,  1, 0, A40, 1, CD, 1, 0, A40,  WD, 0, 1);
    tbl[27] = v(0, A0,  0, 0, A0,  0, Z,  0, 0, A40,  WD, 0, 0);
    tbl[28] = v(1, A60, 1, 0, A40, 0, Z,  0, 0, A40,  WD, 0, 0);
    tbl[29] = v(1, A60, 1, 0, A40, 1, AB, 1, 0, RR ? A60 : A40, WD, RR, !RR);
    tbl[30] = v(!RR, A60, RR, 0, A40, 0, Z, 0, 0, RR ? A60 : A40, WD, 0, 0);
    tbl[31] = v(!RR, A60, RR, 0, A40, 0, Z, 0, 0, RR ? A60 : A40, WD, 0, 0);
    tbl[32] = v(!RR, A60, RR, 0, A40, 1, CD, 1, 0, RR ? A40 : A60, WD, !RR, RR);
    tbl[33] = v(0, A0,  0, 0, A0,  0, Z,  0, 0, RR ? A40 : A60, WD, 0, 0);

    // reset state
    rst = 1'b1;
    drive(0, A0, 0, 0, A0, 0, Z);
    #1;
    chk_all(-1, 0, 0, A0, Z, 0, 0, Z);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < NV; r++) begin
      drive(tbl[r].ir, tbl[r].ia, tbl[r].dr, tbl[r].dw, tbl[r].da, tbl[r].pr, tbl[r].prd);
      #1;
      chk_all(r, tbl[r].epr, tbl[r].epw, tbl[r].ea, tbl[r].ew, tbl[r].eir, tbl[r].edr,
              tbl[r].prd);
      @(negedge clk);
    end

    // abort: writeback granted, reset mid-cycle while waiting on memory
    drive(0, A0, 0, 1, AD, 0, Z);
    #1;
    chk("abort_idle_pmem_write", 100, LW'(pmem_write), LW'(1'b0));
    @(negedge clk);
    #1;
    chk("abort_serve_pmem_write", 101, LW'(pmem_write), LW'(1'b1));
    chk("abort_serve_addr", 101, LW'(pmem_address), LW'(AD));
    #2;
    rst = 1'b1;
    #1;
    chk_all(102, 0, 0, A0, Z, 0, 0, Z);
    @(negedge clk);
    rst = 1'b0;
    // late memory response after the abort
    for (int k = 0; k < 2; k++) begin
      drive(0, A0, 0, 0, A0, 1, CD);
      #1;
      chk_all(103 + k, 0, 0, A0, Z, 0, 0, CD);
      @(negedge clk);
    end
    // icache served normally afterwards
    drive(1, A60, 0, 0, A0, 0, Z);
    #1;
    chk_all(105, 0, 0, A0, Z, 0, 0, Z);
    @(negedge clk);
    drive(1, A60, 0, 0, A0, 0, Z);
    #1;
    chk_all(106, 1, 0, A60, Z, 0, 0, Z);
    @(negedge clk);
    drive(1, A60, 0, 0, A0, 1, AB);
    #1;
    chk_all(107, 1, 0, A60, Z, 1, 0, AB);
    @(negedge clk);
    drive(0, A0, 0, 0, A0, 0, Z);
    #1;
    chk_all(108, 0, 0, A60, Z, 0, 0, Z);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
